// File: rtl/axi_ddc_multi_pkg.sv
// ============================================================================
// Module      : axi_ddc_multi_pkg
// Description : Shared register map, status/control bit positions, response
//               codes and helpers for the multi-channel DDC register slave.
// Revision    : 1.0
// ============================================================================
`default_nettype none

package axi_ddc_multi_pkg;

  localparam logic [2:0] REG_CH     = 3'd0;
  localparam logic [2:0] REG_PINC   = 3'd1;
  localparam logic [2:0] REG_POFF   = 3'd2;
  localparam logic [2:0] REG_RATE   = 3'd3;
  localparam logic [2:0] REG_CTRL   = 3'd4;
  localparam logic [2:0] REG_GATE   = 3'd5;
  localparam logic [2:0] REG_STATUS = 3'd6;
  localparam logic [2:0] REG_AUX    = 3'd7;

  localparam int ST_OVF   = 0;
  localparam int ST_RERR  = 1;
  localparam int ST_EMPTY = 2;
  localparam int ST_FULL  = 3;
  localparam int ST_PEND  = 4;
  localparam int ST_LVL   = 8;

  localparam int CTRL_RESYNC = 0;
  localparam int CTRL_FLUSH  = 1;

  localparam logic [31:0] VERSION = 32'h0001_0000;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  function automatic int entry_width(input int ch_w);
    return ch_w + 64;
  endfunction

  function automatic logic [31:0] strb_merge(input logic [31:0] cur,
                                             input logic [31:0] wd,
                                             input logic [3:0]  strb);
    logic [31:0] r;
    r = cur;
    for (int b = 0; b < 4; b++) begin
      if (strb[b]) r[8*b +: 8] = wd[8*b +: 8];
    end
    return r;
  endfunction

endpackage

`default_nettype wire

// File: rtl/ddc_param_fifo.sv
// ============================================================================
// Module      : ddc_param_fifo
// Description : First-word-fall-through FIFO with flush, full/empty and level.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module ddc_param_fifo #(
  parameter int WIDTH = 72,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         din,
  input  logic                     pop,
  input  logic                     flush,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;

  // Pointers carry one extra wrap bit so level spans 0..DEPTH
  assign level   = wr_ptr - rd_ptr;
  assign empty   = (level == '0);
  assign full    = (level == (AW+1)'(DEPTH));
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign dout    = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr[AW-1:0]] <= din;
  end

endmodule

`default_nettype wire

// File: rtl/axi_ddc_multi_core.sv
// ============================================================================
// Module      : axi_ddc_multi_core
// Description : AXI4-Lite register slave feeding DDC retune entries through a
//               parameter FIFO. Optional macro AXI_DDC_MULTI_RESYNC_DLY_EN
//               adds a programmable resync delay at offset 0x1C.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module axi_ddc_multi_core
  import axi_ddc_multi_pkg::*;
#(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 5,
  parameter int N_CH               = 8,
  parameter int FIFO_DEPTH         = 4,
  localparam int CH_W              = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic                            S_AXI_ACLK,
  input  logic                            S_AXI_ARESETN,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
  input  logic [2:0]                      S_AXI_AWPROT,
  input  logic                            S_AXI_AWVALID,
  output logic                            S_AXI_AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
  input  logic                            S_AXI_WVALID,
  output logic                            S_AXI_WREADY,
  output logic [1:0]                      S_AXI_BRESP,
  output logic                            S_AXI_BVALID,
  input  logic                            S_AXI_BREADY,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
  input  logic [2:0]                      S_AXI_ARPROT,
  input  logic                            S_AXI_ARVALID,
  output logic                            S_AXI_ARREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
  output logic [1:0]                      S_AXI_RRESP,
  output logic                            S_AXI_RVALID,
  input  logic                            S_AXI_RREADY,
  output logic [CH_W-1:0]                 m_ch,
  output logic [31:0]                     m_pinc,
  output logic [31:0]                     m_poff,
  output logic                            m_pvalid,
  input  logic                            m_pready,
  output logic [31:0]                     rate,
  output logic [N_CH-1:0]                 ddc_gate,
  output logic                            resync_soft
);

  localparam int EW = entry_width(CH_W);
  localparam int LW = $clog2(FIFO_DEPTH) + 1;

  logic            clk;
  logic            rst_n;
  logic            aw_w_ready;
  logic            bvalid;
  logic [1:0]      bresp;
  logic            arready;
  logic            rvalid;
  logic [31:0]     rdata;
  logic [31:0]     rd_word;

  logic [31:0]     ch_reg;
  logic [31:0]     pinc;
  logic [31:0]     poff;
  logic [31:0]     rate_r;
  logic [N_CH-1:0] gate_r;
  logic            ovf;
  logic            rerr;
  logic            resync_r;
  logic            pend;

  logic            wr_en;
  logic [2:0]      wr_idx;
  logic [2:0]      rd_idx;
  logic [31:0]     ch_merged;
  logic [31:0]     gate_merged;
  logic            ch_wr;
  logic            ch_bad;
  logic            ctrl_wr;
  logic            st_wr;
  logic            resync_req;
  logic            fifo_push;
  logic            fifo_pop;
  logic            fifo_flush;
  logic            fifo_full;
  logic            fifo_empty;
  logic [LW-1:0]   fifo_level;
  logic [EW-1:0]   fifo_head;
  logic [31:0]     status;
  logic            unused_ok;

  assign clk   = S_AXI_ACLK;
  assign rst_n = S_AXI_ARESETN;

  assign S_AXI_AWREADY = aw_w_ready;
  assign S_AXI_WREADY  = aw_w_ready;
  assign S_AXI_BVALID  = bvalid;
  assign S_AXI_BRESP   = bresp;
  assign S_AXI_ARREADY = arready;
  assign S_AXI_RVALID  = rvalid;
  assign S_AXI_RDATA   = rdata;
  assign S_AXI_RRESP   = RESP_OKAY;

  assign wr_en  = aw_w_ready & S_AXI_AWVALID & S_AXI_WVALID;
  assign wr_idx = S_AXI_AWADDR[4:2];
  assign rd_idx = S_AXI_ARADDR[4:2];

  assign ch_merged   = strb_merge(ch_reg, S_AXI_WDATA, S_AXI_WSTRB);
  assign gate_merged = strb_merge(32'(gate_r), S_AXI_WDATA, S_AXI_WSTRB);
  assign ch_wr       = wr_en && (wr_idx == REG_CH) && (|S_AXI_WSTRB);
  assign ch_bad      = (ch_merged >= 32'(N_CH));
  assign ctrl_wr     = wr_en && (wr_idx == REG_CTRL) && S_AXI_WSTRB[0];
  assign st_wr       = wr_en && (wr_idx == REG_STATUS) && S_AXI_WSTRB[0];
  assign resync_req  = ctrl_wr & S_AXI_WDATA[CTRL_RESYNC];

  // Full is sampled before any same-cycle pop, so a push into a full FIFO is
  // rejected even while the datapath is draining it.
  assign fifo_push  = ch_wr & ~ch_bad & ~fifo_full;
  assign fifo_pop   = m_pvalid & m_pready;
  assign fifo_flush = ctrl_wr & S_AXI_WDATA[CTRL_FLUSH];

  ddc_param_fifo #(
    .WIDTH (EW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (fifo_push),
    .din   ({ch_merged[CH_W-1:0], pinc, poff}),
    .pop   (fifo_pop),
    .flush (fifo_flush),
    .dout  (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (fifo_level)
  );

  assign m_ch        = fifo_head[EW-1 -: CH_W];
  assign m_pinc      = fifo_head[63:32];
  assign m_poff      = fifo_head[31:0];
  assign m_pvalid    = ~fifo_empty;
  assign rate        = rate_r;
  assign ddc_gate    = gate_r;
  assign resync_soft = resync_r;

  assign status = {16'b0, 8'(fifo_level), 3'b0, pend, fifo_full, fifo_empty, rerr, ovf};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      aw_w_ready <= 1'b0;
      bvalid     <= 1'b0;
      bresp      <= RESP_OKAY;
    end else begin
      aw_w_ready <= ~aw_w_ready & S_AXI_AWVALID & S_AXI_WVALID & ~bvalid;
      if (wr_en) begin
        bvalid <= 1'b1;
        bresp  <= (ch_wr && (ch_bad || fifo_full)) ? RESP_SLVERR : RESP_OKAY;
      end else if (S_AXI_BREADY) begin
        bvalid <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ch_reg <= '0;
      pinc   <= '0;
      poff   <= '0;
      rate_r <= '0;
      gate_r <= '1;
      ovf    <= 1'b0;
      rerr   <= 1'b0;
    end else begin
      if (wr_en) begin
        case (wr_idx)
          REG_CH:   ch_reg <= ch_merged;
          REG_PINC: pinc   <= strb_merge(pinc, S_AXI_WDATA, S_AXI_WSTRB);
          REG_POFF: poff   <= strb_merge(poff, S_AXI_WDATA, S_AXI_WSTRB);
          REG_RATE: rate_r <= strb_merge(rate_r, S_AXI_WDATA, S_AXI_WSTRB);
          REG_GATE: gate_r <= gate_merged[N_CH-1:0];
          default: ;
        endcase
      end
      // A set event in the clearing cycle keeps the sticky bit set
      ovf  <= (ch_wr & ~ch_bad & fifo_full) | (ovf & ~(st_wr & S_AXI_WDATA[ST_OVF]));
      rerr <= (ch_wr & ch_bad) | (rerr & ~(st_wr & S_AXI_WDATA[ST_RERR]));
    end
  end

`ifdef AXI_DDC_MULTI_RESYNC_DLY_EN
  logic [15:0] dly;
  logic [15:0] cnt;
  logic [31:0] dly_merged;

  assign dly_merged = strb_merge({16'b0, dly}, S_AXI_WDATA, S_AXI_WSTRB);
  assign unused_ok  = &{1'b0, S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR[1:0],
                        S_AXI_ARADDR[1:0], gate_merged, dly_merged};

  // Counter is preloaded with dly-1 so the pulse lands dly+1 cycles after the write
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dly      <= '0;
      cnt      <= '0;
      pend     <= 1'b0;
      resync_r <= 1'b0;
    end else begin
      resync_r <= 1'b0;
      if (wr_en && (wr_idx == REG_AUX)) dly <= dly_merged[15:0];
      if (resync_req) begin
        if (dly == '0) begin
          resync_r <= 1'b1;
          pend     <= 1'b0;
        end else begin
          cnt  <= dly - 1'b1;
          pend <= 1'b1;
        end
      end else if (pend) begin
        if (cnt == '0) begin
          resync_r <= 1'b1;
          pend     <= 1'b0;
        end else begin
          cnt <= cnt - 1'b1;
        end
      end
    end
  end

  always_comb begin
    rd_word = '0;
    case (rd_idx)
      REG_CH:     rd_word = ch_reg;
      REG_PINC:   rd_word = pinc;
      REG_POFF:   rd_word = poff;
      REG_RATE:   rd_word = rate_r;
      REG_GATE:   rd_word = 32'(gate_r);
      REG_STATUS: rd_word = status;
      REG_AUX:    rd_word = {16'b0, dly};
      default:    rd_word = '0;
    endcase
  end
`else
  assign pend      = 1'b0;
  assign unused_ok = &{1'b0, S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR[1:0],
                       S_AXI_ARADDR[1:0], gate_merged};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) resync_r <= 1'b0;
    else        resync_r <= resync_req;
  end

  always_comb begin
    rd_word = '0;
    case (rd_idx)
      REG_CH:     rd_word = ch_reg;
      REG_PINC:   rd_word = pinc;
      REG_POFF:   rd_word = poff;
      REG_RATE:   rd_word = rate_r;
      REG_GATE:   rd_word = 32'(gate_r);
      REG_STATUS: rd_word = status;
      REG_AUX:    rd_word = VERSION;
      default:    rd_word = '0;
    endcase
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      arready <= 1'b0;
      rvalid  <= 1'b0;
      rdata   <= '0;
    end else begin
      arready <= ~arready & S_AXI_ARVALID & ~rvalid;
      if (arready && S_AXI_ARVALID) begin
        rvalid <= 1'b1;
        rdata  <= rd_word;
      end else if (S_AXI_RREADY) begin
        rvalid <= 1'b0;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_axi_ddc_multi_core.sv
// ============================================================================
// Module      : tb_axi_ddc_multi_core
// Description : Directed plus randomized bench with a queue-based model.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module tb_axi_ddc_multi_core;
  import axi_ddc_multi_pkg::*;

  localparam int NCH   = 8;
  localparam int DEPTH = 4;

  typedef struct {
    logic [31:0] ch;
    logic [31:0] pinc;
    logic [31:0] poff;
  } ent_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [4:0]  awaddr = '0;
  logic        awvalid = 1'b0;
  logic        awready;
  logic [31:0] wdata = '0;
  logic [3:0]  wstrb = '0;
  logic        wvalid = 1'b0;
  logic        wready;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready = 1'b0;
  logic [4:0]  araddr = '0;
  logic        arvalid = 1'b0;
  logic        arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid;
  logic        rready = 1'b0;
  logic [2:0]  m_ch;
  logic [31:0] m_pinc;
  logic [31:0] m_poff;
  logic        m_pvalid;
  logic        m_pready = 1'b0;
  logic [31:0] rate;
  logic [7:0]  ddc_gate;
  logic        resync_soft;

  int checks = 0;
  int failures = 0;

  // Reference model state
  logic [31:0] md_pinc, md_poff, md_rate, md_gate, md_ch, md_dly;
  bit          md_ovf, md_rerr;
  ent_t        q[$];
  logic [1:0]  exp_resp;

  axi_ddc_multi_core #(
    .C_S_AXI_DATA_WIDTH (32),
    .C_S_AXI_ADDR_WIDTH (5),
    .N_CH               (NCH),
    .FIFO_DEPTH         (DEPTH)
  ) dut (
    .S_AXI_ACLK    (clk),
    .S_AXI_ARESETN (rst_n),
    .S_AXI_AWADDR  (awaddr),
    .S_AXI_AWPROT  (3'b000),
    .S_AXI_AWVALID (awvalid),
    .S_AXI_AWREADY (awready),
    .S_AXI_WDATA   (wdata),
    .S_AXI_WSTRB   (wstrb),
    .S_AXI_WVALID  (wvalid),
    .S_AXI_WREADY  (wready),
    .S_AXI_BRESP   (bresp),
    .S_AXI_BVALID  (bvalid),
    .S_AXI_BREADY  (bready),
    .S_AXI_ARADDR  (araddr),
    .S_AXI_ARPROT  (3'b000),
    .S_AXI_ARVALID (arvalid),
    .S_AXI_ARREADY (arready),
    .S_AXI_RDATA   (rdata),
    .S_AXI_RRESP   (rresp),
    .S_AXI_RVALID  (rvalid),
    .S_AXI_RREADY  (rready),
    .m_ch          (m_ch),
    .m_pinc        (m_pinc),
    .m_poff        (m_poff),
    .m_pvalid      (m_pvalid),
    .m_pready      (m_pready),
    .rate          (rate),
    .ddc_gate      (ddc_gate),
    .resync_soft   (resync_soft)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] merge(input logic [31:0] cur, input logic [31:0] d,
                                        input logic [3:0] s);
    logic [31:0] r = cur;
    for (int b = 0; b < 4; b++) if (s[b]) r[8*b +: 8] = d[8*b +: 8];
    return r;
  endfunction

  function automatic logic [31:0] model_status();
    logic [31:0] st = 32'(md_ovf) | (32'(md_rerr) << 1) | (32'(q.size() == 0) << 2) |
                      (32'(q.size() == DEPTH) << 3) | (32'(q.size()) << 8);
    return st;
  endfunction

  function automatic logic [31:0] model_read(input int idx);
    case (idx)
      1: return md_pinc;
      2: return md_poff;
      3: return md_rate;
      5: return md_gate;
      6: return model_status();
`ifdef AXI_DDC_MULTI_RESYNC_DLY_EN
      7: return md_dly;
`else
      7: return VERSION;
`endif
      default: return 32'h0;
    endcase
  endfunction

  task automatic model_write(input int idx, input logic [31:0] d, input logic [3:0] s);
    ent_t e;
    exp_resp = 2'b00;
    case (idx)
      0: if (s != 0) begin
        md_ch = merge(md_ch, d, s);
        if (md_ch >= NCH) begin
          md_rerr = 1; exp_resp = 2'b10;
        end else if (q.size() == DEPTH) begin
          md_ovf = 1; exp_resp = 2'b10;
        end else begin
          e.ch = md_ch; e.pinc = md_pinc; e.poff = md_poff;
          q.push_back(e);
        end
      end
      1: md_pinc = merge(md_pinc, d, s);
      2: md_poff = merge(md_poff, d, s);
      3: md_rate = merge(md_rate, d, s);
      4: if (s[0] && d[1]) q.delete();
      5: md_gate = merge(md_gate, d, s) & 32'hFF;
      6: if (s[0]) begin
        if (d[0]) md_ovf = 0;
        if (d[1]) md_rerr = 0;
      end
`ifdef AXI_DDC_MULTI_RESYNC_DLY_EN
      7: md_dly = merge(md_dly, d, s) & 32'hFFFF;
`endif
      default: ;
    endcase
  endtask

  // Returns one tick after the clock edge that ended the write cycle
  task automatic do_write(input string tag, input logic [4:0] a, input logic [31:0] d,
                          input logic [3:0] s);
    logic [1:0] resp;
    int n = 0;
    model_write(int'(a[4:2]), d, s);
    awaddr = a; wdata = d; wstrb = s; awvalid = 1; wvalid = 1; bready = 1;
    do begin
      @(posedge clk); #1; n++;
    end while (!awready && n < 20);
    check({tag, "_awready"}, 32'(awready), 32'h1);
    @(posedge clk); #1;
    awvalid = 0; wvalid = 0;
    resp = bvalid ? bresp : 2'bxx;
    check({tag, "_bresp"}, 32'(resp), 32'(exp_resp));
  endtask

  task automatic do_read(input string tag, input logic [4:0] a);
    logic [31:0] d;
    int n = 0;
    araddr = a; arvalid = 1; rready = 1;
    do begin
      @(posedge clk); #1; n++;
    end while (!arready && n < 20);
    @(posedge clk); #1;
    arvalid = 0;
    d = rvalid ? rdata : 32'hxxxxxxxx;
    check(tag, d, model_read(int'(a[4:2])));
  endtask

  task automatic check_head(input string tag);
    check({tag, "_pvalid"}, 32'(m_pvalid), 32'(q.size() != 0));
    if (q.size() != 0) begin
      check({tag, "_ch"}, 32'(m_ch), q[0].ch);
      check({tag, "_pinc"}, m_pinc, q[0].pinc);
      check({tag, "_poff"}, m_poff, q[0].poff);
    end
  endtask

  task automatic do_pop(input string tag);
    check_head(tag);
    m_pready = 1;
    @(posedge clk); #1;
    m_pready = 0;
    if (q.size() != 0) void'(q.pop_front());
    check_head({tag, "_after"});
  endtask

  initial begin
    bit saw_early;
    md_pinc = 0; md_poff = 0; md_rate = 0; md_gate = 32'hFF; md_ch = 0; md_dly = 0;
    md_ovf = 0; md_rerr = 0;

    repeat (3) @(posedge clk);
    #1;
    check("rst_pvalid", 32'(m_pvalid), 32'h0);
    check("rst_resync", 32'(resync_soft), 32'h0);
    check("rst_gate_out", 32'(ddc_gate), 32'hFF);
    check("rst_bvalid", 32'(bvalid), 32'h0);
    check("rst_awready", 32'(awready), 32'h0);
    rst_n = 1;
    @(posedge clk); #1;

    do_read("rst_gate", 5'h14);
    do_read("rst_status", 5'h18);
    check("rst_status_lit", model_read(6), 32'h4);
    do_read("aux_reg", 5'h1C);

    // Single entry push
    do_write("pinc", 5'h04, 32'h0100_0000, 4'hF);
    do_write("poff", 5'h08, 32'h0000_0010, 4'hF);
    do_write("ch3", 5'h00, 32'd3, 4'hF);
    check_head("ch3_head");
    check("ch3_mch", 32'(m_ch), 32'd3);
    do_read("status_lvl1", 5'h18);

    // Overflow on the fifth push
    do_write("flush0", 5'h10, 32'h2, 4'h1);
    check("flush0_pvalid", 32'(m_pvalid), 32'h0);
    for (int i = 0; i < 5; i++) do_write("fill", 5'h00, 32'(i), 4'hF);
    do_read("status_ovf", 5'h18);
    check("status_ovf_lit", model_read(6), 32'h409);
    do_write("clr_ovf", 5'h18, 32'h1, 4'h1);
    do_read("status_clr", 5'h18);

    // Range error while full
    do_write("ch8", 5'h00, 32'd8, 4'hF);
    do_read("status_rerr", 5'h18);
    do_write("clr_rerr", 5'h18, 32'h2, 4'h1);

    // Back-to-back pops in push order
    m_pready = 1;
    for (int i = 0; i < DEPTH; i++) begin
      check_head("burst");
      @(posedge clk); #1;
      void'(q.pop_front());
    end
    m_pready = 0;
    check("burst_done", 32'(m_pvalid), 32'h0);

    // Refill then flush
    do_write("refill_a", 5'h00, 32'd7, 4'hF);
    do_write("refill_b", 5'h00, 32'd1, 4'hF);
    do_write("flush1", 5'h10, 32'h2, 4'h1);
    check("flush1_pvalid", 32'(m_pvalid), 32'h0);
    do_read("ctrl_reads0", 5'h10);

    // Resync pulse
`ifdef AXI_DDC_MULTI_RESYNC_DLY_EN
    do_write("dly", 5'h1C, 32'd10, 4'hF);
    do_write("resync", 5'h10, 32'h1, 4'h1);
    saw_early = 0;
    for (int k = 1; k <= 10; k++) begin
      if (resync_soft) saw_early = 1;
      @(posedge clk); #1;
    end
    check("resync_early", 32'(saw_early), 32'h0);
    check("resync_pulse", 32'(resync_soft), 32'h1);
    @(posedge clk); #1;
    check("resync_end", 32'(resync_soft), 32'h0);
`else
    saw_early = 0;
    do_write("resync", 5'h10, 32'h1, 4'h1);
    check("resync_pulse", 32'(resync_soft), 32'h1);
    @(posedge clk); #1;
    check("resync_end", 32'(resync_soft), 32'h0);
    do_write("aux_ignored", 5'h1C, 32'h1234_5678, 4'hF);
    do_read("aux_version", 5'h1C);
`endif

    // Randomized traffic against the model
    for (int it = 0; it < 80; it++) begin
      int op = $urandom_range(0, 7);
      case (op)
        0: do_write("r_pinc", 5'h04, $urandom, 4'($urandom_range(1, 15)));
        1: do_write("r_poff", 5'h08, $urandom, 4'($urandom_range(1, 15)));
        2, 3: begin
          do_write("r_ch", 5'h00, 32'($urandom_range(0, NCH + 1)), 4'hF);
          check_head("r_ch_head");
        end
        4: do_pop("r_pop");
        5: begin
          do_write("r_rate", 5'h0C, $urandom, 4'($urandom_range(1, 15)));
          check("r_rate_out", rate, md_rate);
          do_write("r_gate", 5'h14, $urandom, 4'($urandom_range(0, 15)));
          check("r_gate_out", 32'(ddc_gate), md_gate);
        end
        6: begin
          do_write("r_status", 5'h18, 32'($urandom_range(0, 3)), 4'h1);
          do_read("r_status_rd", 5'h18);
        end
        default: begin
          if ($urandom_range(0, 3) == 0) do_write("r_flush", 5'h10, 32'h2, 4'h1);
          do_read("r_rd_pinc", 5'h04);
          do_read("r_rd_poff", 5'h08);
        end
      endcase
    end
    do_read("final_status", 5'h18);
    check_head("final_head");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/axi_ddc_multi_core.md
Name: axi_ddc_multi_core

Overview:
AXI4-Lite register slave for the multi-channel DDC.
- Holds tuning parameters (pinc, poff), accumulation rate, per-channel gate bits and soft resync.
- Channel programming writes are queued in a parameter FIFO and delivered to the DDC datapath over a valid/ready stream, so software can issue bursts of retunes without losing updates.
- Sits between the PS interconnect and the DDC NCO/accumulator bank.

Parameters:
C_S_AXI_DATA_WIDTH, 32, AXI data width; only 32 supported.
C_S_AXI_ADDR_WIDTH, 5, AXI address width; 8 word registers.
N_CH, 8, number of DDC channels; ch index width CH_W = clog2(N_CH), min 1.
FIFO_DEPTH, 4, parameter FIFO entries; power of 2, at least 2.

Ports:
S_AXI_ACLK  in  1  clock for all logic.
S_AXI_ARESETN  in  1  reset, asynchronous, active-low.
S_AXI_AW*/W*/B*/AR*/R*  per AXI4-Lite  standard slave channels (AWADDR, AWPROT, AWVALID, AWREADY, WDATA, WSTRB, WVALID, WREADY, BRESP, BVALID, BREADY, ARADDR, ARPROT, ARVALID, ARREADY, RDATA, RRESP, RVALID, RREADY); PROT ignored.
m_ch  out  CH_W  channel index of the head FIFO entry.
m_pinc  out  32  phase increment of the head entry.
m_poff  out  32  phase offset of the head entry.
m_pvalid  out  1  head entry valid (FIFO not empty).
m_pready  in  1  datapath accepts the head entry.
rate  out  32  accumulation length (reg 0x0C).
ddc_gate  out  N_CH  per-channel gate (reg 0x14).
resync_soft  out  1  single-cycle resync pulse.

Behaviour:
Register map (word offsets):
- 0x00 CH: write pushes an entry.
- 0x04 PINC, 0x08 POFF, 0x0C RATE: byte-strobed RW.
- 0x10 CTRL: write only; bit0 resync, bit1 flush; reads 0.
- 0x14 GATE: bits [N_CH-1:0], RW.
- 0x18 STATUS: [0] overflow W1C, [1] range_err W1C, [2] empty, [3] full, [15:8] level.
- 0x1C: see Optional Feature.

Reset (async, immediate):
- Registers 0 except GATE = all ones.
- FIFO empty, so m_pvalid = 0.
- resync_soft, BVALID, RVALID, AWREADY, WREADY, ARREADY all 0.
- Reset mid-transaction drops the transaction and all queued entries.

Write channel:
- AW and W are accepted together; AWREADY and WREADY pulse for 1 cycle once both are valid and no response is pending.
- Write takes effect on that cycle.
- BVALID rises the next cycle and holds until BREADY.
- Only one write is outstanding at a time.

Read channel:
- ARREADY pulses 1 cycle after ARVALID.
- RDATA/RVALID are registered on the next cycle; RVALID holds until RREADY.
- A read and a write in the same cycle are independent.

CH write (any WSTRB bit set):
- The merged CH value (byte-strobed) is checked.
- If the value is below N_CH and the FIFO is not full, push {ch, PINC, POFF} using PINC/POFF as they stand before this cycle; BRESP = OKAY.
- If the value is N_CH or above: no push, range_err set, BRESP = SLVERR (2'b10).
- If the FIFO is full: no push, overflow set, BRESP = SLVERR.
- Full is evaluated before a same-cycle pop: a push while full and popping is still rejected.

FIFO:
- First-word-fall-through; m_* show the head entry.
- Pop on m_pvalid & m_pready.
- Push-to-m_pvalid latency: 1 cycle after the write cycle.
- Pointers wrap modulo FIFO_DEPTH; level ranges 0..FIFO_DEPTH.

CTRL flush:
- Empties the FIFO in the write cycle.
- Flush with a simultaneous pop: no error.
- CH and CTRL cannot both be written in the same cycle (single write port).

CTRL resync:
- bit0 = 1 with WSTRB[0] produces resync_soft high for exactly 1 cycle, on the cycle after the write.

STATUS W1C:
- Writing 1 clears the sticky bit.
- A set event in the same cycle as the clear wins (bit stays set).

Optional Feature:
Macro AXI_DDC_MULTI_RESYNC_DLY_EN.
- Defined: 0x1C is RESYNC_DLY (RW, 16 bits used). A resync request loads a down-counter with RESYNC_DLY, and resync_soft pulses when the counter expires, i.e. RESYNC_DLY+1 cycles after the write cycle. A new request while counting reloads the counter (single pulse only). STATUS[4] = resync pending.
- Not defined: 0x1C reads the VERSION constant and writes are ignored. Resync latency is 1 cycle. STATUS[4] reads 0.

Decomposition:
- Package axi_ddc_multi_pkg holds:
  - register word offsets and STATUS/CTRL bit positions;
  - the VERSION constant;
  - the RESP_OKAY/RESP_SLVERR codes;
  - the FIFO entry width function (CH_W+64).
- Sub-module ddc_param_fifo: parametrised FWFT FIFO (width, depth) with push, pop, flush, full, empty and level outputs.

Test Plan:
- Reset → read GATE = 0x000000FF with N_CH=8; STATUS = 0x00000004 (empty); m_pvalid = 0.
- Write PINC=0x01000000, POFF=0x00000010, CH=3 with m_pready=0 → m_pvalid=1 one cycle after the write; m_ch=3, m_pinc=0x01000000, m_poff=0x10; BRESP=OKAY; STATUS level=1.
- m_pready=0, 5 CH writes with FIFO_DEPTH=4 → 5th BRESP=SLVERR; STATUS = 0x0409 (overflow, full, level 4). Write STATUS=0x1 → overflow cleared.
- Write CH=8 with N_CH=8 → BRESP=SLVERR, no push, STATUS[1]=1.
- Fill 4 entries, hold m_pready=1 → 4 pops in 4 consecutive cycles in push order. Refill, write CTRL=0x2 → m_pvalid=0 next cycle.
- Write CTRL=0x1 → resync_soft high exactly 1 cycle. With AXI_DDC_MULTI_RESYNC_DLY_EN and RESYNC_DLY=10 → pulse 11 cycles after the write cycle.
